// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes and register-index decode helpers
// shared by the register slave and its test bench.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the word index carried in ADDR[9:2].
  localparam int REG_IDX_W = 8;

  // True when a word address (ADDR[31:2]) selects an implemented register.
  function automatic logic word_in_range(input logic [29:0] word, input int num_regs);
    return (word[29:REG_IDX_W] == '0) && (int'(word[REG_IDX_W-1:0]) < num_regs);
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite channel bundle (AW, W, B, AR, R) without PROT,
// with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_strb_merge.sv
// axi4_lite_strb_merge: splices the strobed byte lanes of new write data
// over the old register value. Purely combinational.
module axi4_lite_strb_merge (
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  logic [31:0] lane_mask;

  // Expand each strobe bit to a byte mask, then take new bytes where enabled.
  always_comb begin
    lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    merged    = (old & ~lane_mask) | (wdata & lane_mask);
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite bank of NUM_REGS 32-bit read/write
// registers. One write is outstanding at a time; reads run alongside.
// Define AXI4L_REGS_ADDR_ERR_EN to answer out-of-range accesses with SLVERR
// instead of OKAY.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi4_lite_if.slave                s_axi,
  output logic [NUM_REGS-1:0][31:0] regs_o,
  output logic [NUM_REGS-1:0]       wr_pulse_o
);

`ifdef AXI4L_REGS_ADDR_ERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  logic                      aw_held;
  logic                      w_held;
  logic [29:0]               aw_word;
  logic [31:0]               w_data;
  logic [3:0]                w_strb;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      rvalid;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic [NUM_REGS-1:0][31:0] regs;
  logic                      aw_ready;
  logic                      w_ready;
  logic                      ar_ready;
  logic                      commit;
  logic                      aw_in_range;
  logic                      ar_in_range;
  logic [REG_IDX_W-1:0]      aw_idx;
  logic [REG_IDX_W-1:0]      ar_idx;
  logic [31:0]               wr_old;
  logic [31:0]               wr_merged;
  logic [31:0]               rd_sel;
  logic                      unused_addr_lsb;

  // Byte offsets inside a word carry no meaning for this register bank.
  assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign aw_ready = !aw_held && !bvalid;
  assign w_ready  = !w_held && !bvalid;
  assign ar_ready = !rvalid;
  assign commit   = aw_held && w_held;

  assign aw_idx      = aw_word[REG_IDX_W-1:0];
  assign aw_in_range = word_in_range(aw_word, NUM_REGS);
  assign ar_idx      = s_axi.araddr[REG_IDX_W+1:2];
  assign ar_in_range = word_in_range(s_axi.araddr[31:2], NUM_REGS);

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.arready = ar_ready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = rresp;
  assign regs_o        = regs;

  // Select the register under the held write address and the live read address.
  always_comb begin
    wr_old = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == REG_IDX_W'(i)) wr_old = regs[i];
      if (ar_idx == REG_IDX_W'(i)) rd_sel = regs[i];
    end
  end

  axi4_lite_strb_merge u_merge (
    .old    (wr_old),
    .wdata  (w_data),
    .wstrb  (w_strb),
    .merged (wr_merged)
  );

  // Write address/data capture, commit and write-response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_word <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (s_axi.awvalid && aw_ready) begin
        aw_held <= 1'b1;
        aw_word <= s_axi.awaddr[31:2];
      end
      if (s_axi.wvalid && w_ready) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_in_range ? RESP_OKAY : OOR_RESP;
      end else if (bvalid && s_axi.bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register storage and the per-register update strobe; empty strobes change nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= {NUM_REGS{RESET_VALUE}};
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit && aw_in_range && (w_strb != 4'b0000)) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == REG_IDX_W'(i)) begin
            regs[i]       <= wr_merged;
            wr_pulse_o[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read channel: one-cycle latency, result held until the master accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (s_axi.arvalid && ar_ready) begin
      rvalid <= 1'b1;
      rdata  <= ar_in_range ? rd_sel : 32'h0;
      rresp  <= ar_in_range ? RESP_OKAY : OOR_RESP;
    end else if (rvalid && s_axi.rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs: directed scenarios plus randomized reads and writes
// for axi4_lite_slave_regs, checked against an array model of the registers.
module tb_axi4_lite_slave_regs;
  import axi4_lite_pkg::*;

  localparam int          NUM_REGS    = 8;
  localparam logic [31:0] RESET_VALUE = 32'hA5A5_0F0F;
`ifdef AXI4L_REGS_ADDR_ERR_EN
  localparam logic [1:0]  OOR_RESP    = 2'b10;
`else
  localparam logic [1:0]  OOR_RESP    = 2'b00;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REGS-1:0][31:0] regs_o;
  logic [NUM_REGS-1:0]       wr_pulse_o;
  logic [31:0]               model [NUM_REGS];
  int                        num_checks = 0;
  int                        num_pass   = 0;

  axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_regs #(
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (bus),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case a scenario wedges outside its own bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    num_checks++;
    if (got === exp) num_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[31:10] == 22'd0) && (int'(a[9:2]) < NUM_REGS);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic bus_idle();
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VALUE;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    checkOutput("rst_resps", {bus.bresp, bus.rresp}, 4'b0000);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_pulse", wr_pulse_o, '0);
    checkOutput("rst_regs", regs_o, model_flat());
    rst_n = 1'b1;
    #1;
    checkOutput("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit stall_aw);
    bit                  aw_done, w_done, aw_hs, w_hs;
    int                  cyc;
    logic [1:0]          exp_resp;
    logic [NUM_REGS-1:0] exp_pulse;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checkOutput("wr_handshake", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    checkOutput("bvalid_early", bus.bvalid, 1'b0);
    @(posedge clk); #1;
    exp_pulse = '0;
    exp_resp  = addr_ok(addr) ? 2'b00 : OOR_RESP;
    if (addr_ok(addr) && strb != 4'b0000) begin
      model[int'(addr[9:2])] = byte_merge(model[int'(addr[9:2])], data, strb);
      exp_pulse[int'(addr[9:2])] = 1'b1;
    end
    checkOutput("bvalid_rise", bus.bvalid, 1'b1);
    checkOutput("bresp", bus.bresp, exp_resp);
    checkOutput("regs_after_wr", regs_o, model_flat());
    checkOutput("wr_pulse", wr_pulse_o, exp_pulse);
    for (int i = 0; i < b_dly; i++) begin
      if (stall_aw) begin
        bus.awvalid = 1'b1;
        bus.awaddr  = addr ^ 32'h4;
      end
      checkOutput("bhold_readies", {bus.awready, bus.wready}, 2'b00);
      @(posedge clk); #1;
      checkOutput("bvalid_hold", bus.bvalid, 1'b1);
      checkOutput("bresp_hold", bus.bresp, exp_resp);
      checkOutput("wr_pulse_once", wr_pulse_o, '0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.awvalid = 1'b0;
    checkOutput("bvalid_clear", bus.bvalid, 1'b0);
    checkOutput("wr_readies_back", {bus.awready, bus.wready}, 2'b11);
    checkOutput("wr_pulse_done", wr_pulse_o, '0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    bit          hs;
    int          cyc;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    hs = 1'b0; cyc = 0;
    bus.araddr = addr;
    while (!hs && cyc < 40) begin
      bus.arvalid = (cyc >= ar_dly);
      hs = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    checkOutput("ar_handshake", hs, 1'b1);
    if (!hs) return;
    exp_data = 32'h0;
    exp_resp = OOR_RESP;
    if (addr_ok(addr)) begin
      exp_data = model[int'(addr[9:2])];
      exp_resp = 2'b00;
    end
    checkOutput("rvalid_rise", bus.rvalid, 1'b1);
    checkOutput("rdata", bus.rdata, exp_data);
    checkOutput("rresp", bus.rresp, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      checkOutput("rhold_arready", bus.arready, 1'b0);
      @(posedge clk); #1;
      checkOutput("rhold", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, exp_resp, exp_data});
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    checkOutput("rvalid_clear", bus.rvalid, 1'b0);
    checkOutput("arready_back", bus.arready, 1'b1);
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      a = {22'd0, 8'($urandom_range(0, NUM_REGS + 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a[31:10] = 22'($urandom_range(1, 4095));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      else
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_idle();
    do_reset();

    // Same-cycle AW/W to register 1.
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
    checkOutput("req026_reg1", regs_o[1], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobes.
    axi_write(32'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 1'b0);
    axi_write(32'h08, 32'h12345678, 4'b0101, 3, 0, 0, 1'b0);
    checkOutput("req027_reg2", regs_o[2], 32'hAA34AA78);

    // Back-pressured response with a second AW waiting, then that write.
    axi_write(32'h14, 32'hCAFE0001, 4'hF, 0, 0, 5, 1'b1);
    axi_write(32'h10, 32'hCAFE0002, 4'hF, 0, 1, 0, 1'b0);

    // Empty strobe, out-of-range writes and reads.
    axi_write(32'h18, 32'hFFFFFFFF, 4'b0000, 1, 0, 0, 1'b0);
    axi_write(32'h20, 32'h0BAD0BAD, 4'hF, 0, 0, 1, 1'b0);
    axi_write(32'h0000_0404, 32'h0BAD0BAD, 4'hF, 0, 0, 0, 1'b0);
    axi_read(32'h40, 0, 2);
    axi_read(32'h0000_0408, 1, 0);
    axi_read(32'h04, 0, 0);

    // Read captured on the commit edge of a write to the same register.
    axi_write(32'h0C, 32'h11, 4'hF, 0, 0, 0, 1'b0);
    bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    checkOutput("req030_wr_ready", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    checkOutput("req030_ar_ready", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    model[3] = 32'h55;
    checkOutput("req030_valids", {bus.bvalid, bus.rvalid}, 2'b11);
    checkOutput("req030_rdata_old", bus.rdata, 32'h11);
    checkOutput("req030_regs", regs_o, model_flat());
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    checkOutput("req030_clear", {bus.bvalid, bus.rvalid}, 2'b00);
    axi_read(32'h0C, 0, 0);

    // Reset with only AW held: the half write is dropped.
    bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    checkOutput("req031_aw_held", {bus.awready, bus.wready}, 2'b01);
    do_reset();
    axi_write(32'h1C, 32'h600DF00D, 4'hF, 0, 2, 0, 1'b0);
    axi_read(32'h1C, 0, 0);

    applyStimulus(60);

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit read/write registers (2..256).
REQ-002 SHALL have parameter RESET_VALUE, default 32'h0000_0000, giving the reset content of every register.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_axi, axi4_lite_if.slave modport (ADDR_WIDTH 32, DATA_WIDTH 32): the AXI4-Lite responder end.
REQ-006 SHALL have port regs_o, output, NUM_REGS x 32 bits: current register contents, driven to downstream logic.
REQ-007 SHALL have port wr_pulse_o, output, NUM_REGS bits: one-cycle strobe, coincident with the register update.

Function
REQ-008 SHALL decode the word index as ADDR[9:2]; ADDR[1:0] is ignored; an address is in range iff index < NUM_REGS and ADDR[31:10] == 0.
REQ-009 SHALL accept AW and W independently and in either order, holding each in an aw_held/w_held flag.
REQ-010 SHALL drive AWREADY = !aw_held && !BVALID and WREADY = !w_held && !BVALID, so at most one write is outstanding.
REQ-011 SHALL commit the write on the clock edge where aw_held && w_held, merging WDATA per WSTRB byte lane, setting BVALID and clearing both flags.
REQ-012 SHALL make the updated value visible on regs_o in the same cycle BVALID first rises: two cycles after the later of the AW/W handshakes.
REQ-013 SHALL hold BVALID and BRESP stable until BREADY is sampled high; BVALID clears on that edge.
REQ-014 SHALL treat WSTRB == 4'b0000 as a no-op write with BRESP OKAY and no wr_pulse_o.
REQ-015 SHALL drive ARREADY = !RVALID; on an AR handshake, RDATA/RRESP register and RVALID rises the next cycle (read latency 1).
REQ-016 SHALL hold RVALID, RDATA and RRESP stable until RREADY is sampled high.
REQ-017 SHALL run the read and write paths concurrently; a read captured on the same edge as a commit to the same register returns the old value.
REQ-018 SHALL use RESP_OKAY (2'b00) for every in-range access.

Reset
REQ-019 SHALL, on rst_n low, asynchronously clear BVALID, RVALID, aw_held, w_held and wr_pulse_o, and load every register with RESET_VALUE.
REQ-020 SHALL drive BRESP/RRESP = 2'b00 and RDATA = 0 while in reset; AWREADY, WREADY and ARREADY are 1 in the first cycle after release.
REQ-021 SHALL abandon a half-received write (only AW or only W held) on reset, with no register update.

Configuration
REQ-022 SHALL, with macro AXI4L_REGS_ADDR_ERR_EN defined, answer out-of-range accesses with SLVERR (2'b10), leaving registers unchanged and returning RDATA = 0.
REQ-023 SHALL, without AXI4L_REGS_ADDR_ERR_EN, answer out-of-range accesses with OKAY, RDATA = 0 and writes ignored.

Structure
REQ-024 SHALL take RESP_OKAY, RESP_SLVERR and the REG_IDX_W localparam helper from shared package axi4_lite_pkg.
REQ-025 SHALL place the byte-lane merge in sub-module axi4_lite_strb_merge (old, wdata, wstrb -> merged); all state stays in the top module.

Verification
REQ-026 SHALL cover: AW 0x04 and W 0xDEADBEEF/4'hF in the same cycle -> BVALID 2 cycles later, BRESP 00, regs_o[1] = 0xDEADBEEF, wr_pulse_o[1] one cycle.
REQ-027 SHALL cover: W 0x12345678/4'b0101 three cycles before AW 0x08 on a register holding 0xAAAAAAAA -> regs_o[2] = 0xAA34AA78.
REQ-028 SHALL cover: BREADY held low for 5 cycles -> BVALID stays high, AWREADY/WREADY stay low, and a second AW stalls until the B handshake.
REQ-029 SHALL cover: AR 0x40 with NUM_REGS = 8 -> RRESP 10 and RDATA 0 with the macro; RRESP 00 and RDATA 0 without it.
REQ-030 SHALL cover: AR 0x0C on the commit edge of write 0x55 to 0x0C (old value 0x11) -> RDATA 0x11, and a following read returns 0x55.
REQ-031 SHALL cover: rst_n pulsed low with only AW held -> no update and all valids low; the next full write completes normally.
